// File: rtl/ps2_bbc_keymatrix.sv
// PS/2 Set-2 scancode decoder feeding a 10x8 BBC keyboard matrix, with
// manual/autoscan column readout and a separate BREAK-key output (F12).
module ps2_bbc_keymatrix #(
  parameter logic [7:0] LINKS = 8'h00
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       clk_en,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  input  logic       AUTOSCAN,
  input  logic [3:0] COL,
  input  logic [2:0] ROW,
  output logic       KEY_PRESSED,
  output logic       COL_IRQ,
  output logic [3:0] SCAN_COL,
  output logic       nBREAK
);

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXTBRK, SKIP} state_t;

  state_t          state_q, state_d;
  logic [9:0][7:0] matrix_q, matrix_d;
  logic [9:0][7:0] links_mat;
  logic [9:0][7:0] eff_mat;
  logic [2:0]      skip_q, skip_d;
  logic [3:0]      scan_q, scan_d;
  logic            irq_q, irq_d;
  logic            nbreak_q, nbreak_d;
  logic [7:0]      norm_map, ext_map;
  logic [3:0]      irq_col;
  logic            irq_comb;

  // Option links live in row 0 of columns 2..9 and are never stored in the matrix.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_links
      if (gi >= 2) begin : g_on
        assign links_mat[gi] = {7'b0, LINKS[gi-2]};
      end else begin : g_off
        assign links_mat[gi] = 8'h00;
      end
    end
  endgenerate

  assign eff_mat     = matrix_q | links_mat;
  assign KEY_PRESSED = (COL <= 4'd9) ? eff_mat[COL][ROW] : 1'b0;

  // Keymap: bit 7 set means unmapped; otherwise {row[6:4], col[3:0]}.
  always_comb begin
    norm_map = 8'hFF;
    case (DATA_IN)
      8'h12, 8'h59: norm_map = 8'h00;
      8'h14: norm_map = 8'h01;  8'h58: norm_map = 8'h40;  8'h0D: norm_map = 8'h60;
      8'h76: norm_map = 8'h70;  8'h5A: norm_map = 8'h49;  8'h66: norm_map = 8'h59;
      8'h29: norm_map = 8'h62;
      8'h05: norm_map = 8'h71;  8'h06: norm_map = 8'h72;  8'h04: norm_map = 8'h73;
      8'h0C: norm_map = 8'h14;  8'h03: norm_map = 8'h74;  8'h0B: norm_map = 8'h75;
      8'h83: norm_map = 8'h16;  8'h0A: norm_map = 8'h76;  8'h01: norm_map = 8'h77;
      8'h09: norm_map = 8'h20;
      8'h16: norm_map = 8'h30;  8'h1E: norm_map = 8'h31;  8'h26: norm_map = 8'h11;
      8'h25: norm_map = 8'h12;  8'h2E: norm_map = 8'h13;  8'h36: norm_map = 8'h34;
      8'h3D: norm_map = 8'h24;  8'h3E: norm_map = 8'h15;  8'h46: norm_map = 8'h26;
      8'h45: norm_map = 8'h27;
      8'h15: norm_map = 8'h10;  8'h1D: norm_map = 8'h21;  8'h24: norm_map = 8'h22;
      8'h2D: norm_map = 8'h33;  8'h2C: norm_map = 8'h23;  8'h35: norm_map = 8'h44;
      8'h3C: norm_map = 8'h35;  8'h43: norm_map = 8'h25;  8'h44: norm_map = 8'h36;
      8'h4D: norm_map = 8'h37;  8'h1C: norm_map = 8'h41;  8'h1B: norm_map = 8'h51;
      8'h23: norm_map = 8'h32;  8'h2B: norm_map = 8'h43;  8'h34: norm_map = 8'h53;
      8'h33: norm_map = 8'h54;  8'h3B: norm_map = 8'h45;  8'h42: norm_map = 8'h46;
      8'h4B: norm_map = 8'h56;  8'h1A: norm_map = 8'h61;  8'h22: norm_map = 8'h42;
      8'h21: norm_map = 8'h52;  8'h2A: norm_map = 8'h63;  8'h32: norm_map = 8'h64;
      8'h31: norm_map = 8'h55;  8'h3A: norm_map = 8'h65;
      8'h4E: norm_map = 8'h17;  8'h55: norm_map = 8'h18;  8'h0E: norm_map = 8'h28;
      8'h54: norm_map = 8'h38;  8'h5B: norm_map = 8'h58;  8'h4C: norm_map = 8'h57;
      8'h52: norm_map = 8'h48;  8'h41: norm_map = 8'h66;  8'h49: norm_map = 8'h67;
      8'h4A: norm_map = 8'h68;  8'h5D: norm_map = 8'h78;
      default: norm_map = 8'hFF;
    endcase
  end

  always_comb begin
    ext_map = 8'hFF;
    case (DATA_IN)
      8'h75: ext_map = 8'h39;  8'h72: ext_map = 8'h29;  8'h6B: ext_map = 8'h19;
      8'h74: ext_map = 8'h79;  8'h14: ext_map = 8'h01;  8'h5A: ext_map = 8'h49;
      8'h69: ext_map = 8'h69;
      default: ext_map = 8'hFF;
    endcase
  end

  // Row 0 is excluded so Shift, Ctrl and links never raise a column interrupt.
  assign irq_col = AUTOSCAN ? scan_q : COL;
  always_comb begin
    irq_comb = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (irq_col == 4'(c)) irq_comb = |matrix_q[c][7:1];
    end
  end

  always_comb begin
    state_d  = state_q;
    matrix_d = matrix_q;
    skip_d   = skip_q;
    scan_d   = scan_q;
    irq_d    = irq_q;
    nbreak_d = nbreak_q;
    if (clk_en) begin
      if (AUTOSCAN) scan_d = (scan_q == 4'd9) ? 4'd0 : scan_q + 4'd1;
      irq_d = irq_comb;
      if (DATA_VALID) begin
        case (state_q)
          IDLE: begin
            case (DATA_IN)
              8'hE0: state_d = EXT;
              8'hF0: state_d = BRK;
              8'hE1: begin
                state_d = SKIP;
                skip_d  = 3'd7;
              end
              8'h00, 8'hFF: begin
                matrix_d = '0;
                nbreak_d = 1'b1;
              end
              8'hFA, 8'hAA, 8'hEE, 8'hFE: ;
              8'h07: nbreak_d = 1'b0;
              default: if (!norm_map[7]) matrix_d[norm_map[3:0]][norm_map[6:4]] = 1'b1;
            endcase
          end
          BRK: begin
            state_d = IDLE;
            if (DATA_IN == 8'h07) nbreak_d = 1'b1;
            else if (!norm_map[7]) matrix_d[norm_map[3:0]][norm_map[6:4]] = 1'b0;
          end
          EXT: begin
            state_d = IDLE;
            if (DATA_IN == 8'hF0) state_d = EXTBRK;
            else if (DATA_IN != 8'hE0 && DATA_IN != 8'h12 && !ext_map[7])
              matrix_d[ext_map[3:0]][ext_map[6:4]] = 1'b1;
          end
          EXTBRK: begin
            state_d = IDLE;
            if (!ext_map[7]) matrix_d[ext_map[3:0]][ext_map[6:4]] = 1'b0;
          end
          SKIP: begin
            skip_d = skip_q - 3'd1;
            if (skip_q <= 3'd1) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      matrix_q <= '0;
      skip_q   <= 3'd0;
      scan_q   <= 4'd0;
      irq_q    <= 1'b0;
      nbreak_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      matrix_q <= matrix_d;
      skip_q   <= skip_d;
      scan_q   <= scan_d;
      irq_q    <= irq_d;
      nbreak_q <= nbreak_d;
    end
  end

  assign COL_IRQ  = irq_q;
  assign SCAN_COL = scan_q;
  assign nBREAK   = nbreak_q;

endmodule

// File: tb/tb_ps2_bbc_keymatrix.sv
// Directed bench for ps2_bbc_keymatrix: scancode sequences with hand-computed
// matrix, BREAK and column-interrupt expectations.
module tb_ps2_bbc_keymatrix;

  logic       clk = 1'b0;
  logic       nRESET = 1'b0;
  logic       clk_en = 1'b1;
  logic [7:0] DATA_IN = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       AUTOSCAN = 1'b0;
  logic [3:0] COL = 4'd0;
  logic [2:0] ROW = 3'd0;
  logic       KEY_PRESSED;
  logic       COL_IRQ;
  logic [3:0] SCAN_COL;
  logic       nBREAK;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int exp_scan = 0;
  int prev_scan = 0;

  ps2_bbc_keymatrix #(.LINKS(8'h81)) dut (
    .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .DATA_IN(DATA_IN),
    .DATA_VALID(DATA_VALID), .AUTOSCAN(AUTOSCAN), .COL(COL), .ROW(ROW),
    .KEY_PRESSED(KEY_PRESSED), .COL_IRQ(COL_IRQ), .SCAN_COL(SCAN_COL), .nBREAK(nBREAK)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; the scan-counter reference advances with it.
  task automatic tick();
    @(posedge clk);
    prev_scan = exp_scan;
    if (!nRESET) exp_scan = 0;
    else if (clk_en && AUTOSCAN) exp_scan = (exp_scan == 9) ? 0 : exp_scan + 1;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    DATA_IN = b;
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    $display("byte %02h sent (clk_en=%0b)", b, clk_en);
  endtask

  task automatic check_key(input string tag, input logic [3:0] c, input logic [2:0] r,
                           input logic exp);
    COL = c;
    ROW = r;
    #1;
    check_eq(tag, 32'(KEY_PRESSED), 32'(exp));
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    tick();
    tick();
    nRESET = 1'b1;
  endtask

  initial begin
    do_reset();
    check_eq("rst_irq", 32'(COL_IRQ), 32'd0);
    check_eq("rst_scan", 32'(SCAN_COL), 32'd0);
    check_eq("rst_nbreak", 32'(nBREAK), 32'd1);
    check_key("rst_a", 4'd1, 3'd4, 1'b0);

    // Normal make/break
    send_byte(8'h1C);
    check_key("a_make", 4'd1, 3'd4, 1'b1);
    send_byte(8'hF0); send_byte(8'h1C);
    check_key("a_break", 4'd1, 3'd4, 1'b0);
    send_byte(8'h29);
    check_key("space_make", 4'd2, 3'd6, 1'b1);
    send_byte(8'h29);
    check_key("space_typematic", 4'd2, 3'd6, 1'b1);
    send_byte(8'hF0); send_byte(8'h29);
    check_key("space_break", 4'd2, 3'd6, 1'b0);

    // Extended codes
    send_byte(8'hE0); send_byte(8'h75);
    check_key("up_make", 4'd9, 3'd3, 1'b1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check_key("up_break", 4'd9, 3'd3, 1'b0);
    send_byte(8'h75);
    check_key("kp8_unmapped", 4'd9, 3'd3, 1'b0);
    send_byte(8'h1C);
    check_key("idle_after_kp8", 4'd1, 3'd4, 1'b1);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'h14);
    check_key("rctrl_make", 4'd1, 3'd0, 1'b1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    check_key("rctrl_break", 4'd1, 3'd0, 1'b0);
    send_byte(8'hE0); send_byte(8'h12);
    check_key("fake_shift", 4'd0, 3'd0, 1'b0);

    // F12 BREAK key and overflow clear
    send_byte(8'h07);
    check_eq("f12_make", 32'(nBREAK), 32'd0);
    send_byte(8'hF0); send_byte(8'h07);
    check_eq("f12_break", 32'(nBREAK), 32'd1);
    send_byte(8'h1C); send_byte(8'h07);
    check_key("a_before_ff", 4'd1, 3'd4, 1'b1);
    send_byte(8'hFF);
    check_key("ff_clears_a", 4'd1, 3'd4, 1'b0);
    check_eq("ff_nbreak", 32'(nBREAK), 32'd1);

    // Option links and out-of-range column
    check_key("link_col2", 4'd2, 3'd0, 1'b1);
    check_key("link_col9", 4'd9, 3'd0, 1'b1);
    check_key("link_col3", 4'd3, 3'd0, 1'b0);
    check_key("col_oob", 4'd12, 3'd0, 1'b0);

    // Pause sequence is swallowed
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    check_key("pause_ctrl", 4'd1, 3'd0, 1'b0);
    send_byte(8'h1C);
    check_key("pause_then_a", 4'd1, 3'd4, 1'b1);

    // Autoscan: Shift alone never interrupts
    send_byte(8'hFF);
    send_byte(8'h12);
    check_key("shift_make", 4'd0, 3'd0, 1'b1);
    COL = 4'd0;
    AUTOSCAN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("shift_irq", 32'(COL_IRQ), 32'd0);
      check_eq("scan_col", 32'(SCAN_COL), 32'(exp_scan));
    end
    send_byte(8'h1C);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("scan_irq", 32'(COL_IRQ), (prev_scan == 1) ? 32'd1 : 32'd0);
      check_eq("scan_col", 32'(SCAN_COL), 32'(exp_scan));
      if (prev_scan == 9) check_eq("scan_wrap", 32'(SCAN_COL), 32'd0);
    end

    // Manual column interrupt
    AUTOSCAN = 1'b0;
    COL = 4'd1;
    tick();
    check_eq("man_irq_col1", 32'(COL_IRQ), 32'd1);
    check_eq("scan_hold", 32'(SCAN_COL), 32'(exp_scan));
    COL = 4'd12;
    tick();
    check_eq("man_irq_oob", 32'(COL_IRQ), 32'd0);
    COL = 4'd0;
    tick();
    check_eq("man_irq_col0", 32'(COL_IRQ), 32'd0);

    // Reset mid-sequence discards the prefix
    send_byte(8'hE0);
    do_reset();
    check_eq("rst2_scan", 32'(SCAN_COL), 32'd0);
    check_key("rst2_shift", 4'd0, 3'd0, 1'b0);
    check_key("rst2_a", 4'd1, 3'd4, 1'b0);
    send_byte(8'h1C);
    check_key("a_after_rst", 4'd1, 3'd4, 1'b1);

    // Strobes without clk_en are ignored
    clk_en = 1'b0;
    send_byte(8'hF0);
    send_byte(8'h29);
    clk_en = 1'b1;
    check_key("noen_space", 4'd2, 3'd6, 1'b0);
    send_byte(8'h1C);
    check_key("noen_f0_ignored", 4'd1, 3'd4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
